// File: rtl/rosc_meas_ctrl.sv
// Ring-oscillator aging measurement sequencer: reference leg, then stressed leg, reports both counts and their difference.
// Optional build macro ROSC_STRESS_EN keeps every stressed leg running while idle.
module rosc_meas_ctrl #(
    parameter int NUM_ROSC      = 4,
    parameter int SEL_W         = 2,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_CYCLES   = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [SEL_W-1:0]    sel_i,
    input  logic [NUM_ROSC-1:0] ref_tgl_i,
    input  logic [NUM_ROSC-1:0] str_tgl_i,
    output logic [NUM_ROSC-1:0] ref_en_o,
    output logic [NUM_ROSC-1:0] str_en_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [CNT_W-1:0]    cnt_ref_o,
    output logic [CNT_W-1:0]    cnt_str_o,
    output logic [CNT_W:0]      delta_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETTLE_R = 3'd1;
    localparam logic [2:0] S_COUNT_R  = 3'd2;
    localparam logic [2:0] S_SETTLE_S = 3'd3;
    localparam logic [2:0] S_COUNT_S  = 3'd4;
    localparam logic [2:0] S_FIN      = 3'd5;

    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0]    SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]    GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [SEL_W:0]      NUM_L       = NUM_ROSC[SEL_W:0];
    localparam logic [NUM_ROSC-1:0] ONE         = NUM_ROSC'(1);

    logic [2:0]          state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [2:0]          sync_q;
    logic [CNT_W-1:0]    cnt_ref_q, cnt_ref_d;
    logic [CNT_W-1:0]    cnt_str_q, cnt_str_d;
    logic [CNT_W:0]      delta_q, delta_d;
    logic                err_q, err_d;

    logic [NUM_ROSC-1:0] sel_oh;
    logic                ref_phase, str_phase, tgl_sel, edge_w, tmr_last;

    assign sel_oh    = ONE << sel_q;
    assign ref_phase = (state_q == S_SETTLE_R) || (state_q == S_COUNT_R);
    assign str_phase = (state_q == S_SETTLE_S) || (state_q == S_COUNT_S);
    // The pipe follows whichever leg is live; the settle window flushes stale samples after a switch.
    assign tgl_sel   = ref_phase ? |(ref_tgl_i & sel_oh) : |(str_tgl_i & sel_oh);
    assign edge_w    = sync_q[1] ^ sync_q[2];
    assign tmr_last  = ref_phase || str_phase ?
                       (((state_q == S_SETTLE_R) || (state_q == S_SETTLE_S)) ? (tmr_q == SETTLE_LAST)
                                                                               : (tmr_q == GATE_LAST))
                       : 1'b0;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q + 1'b1;
        sel_d     = sel_q;
        cnt_ref_d = cnt_ref_q;
        cnt_str_d = cnt_str_q;
        delta_d   = delta_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (start_i) begin
                    if ({1'b0, sel_i} < NUM_L) begin
                        sel_d     = sel_i;
                        cnt_ref_d = '0;
                        cnt_str_d = '0;
                        delta_d   = '0;
                        state_d   = S_SETTLE_R;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETTLE_R: if (tmr_last) begin state_d = S_COUNT_R; tmr_d = '0; end
            S_COUNT_R: begin
                if (edge_w && (cnt_ref_q != '1)) cnt_ref_d = cnt_ref_q + 1'b1;
                if (tmr_last) begin state_d = S_SETTLE_S; tmr_d = '0; end
            end
            S_SETTLE_S: if (tmr_last) begin state_d = S_COUNT_S; tmr_d = '0; end
            S_COUNT_S: begin
                if (edge_w && (cnt_str_q != '1)) cnt_str_d = cnt_str_q + 1'b1;
                if (tmr_last) begin
                    state_d = S_FIN;
                    tmr_d   = '0;
                    // Uses the final stressed count so DELTA is already valid while DONE is high.
                    delta_d = {1'b0, cnt_ref_q} - {1'b0, cnt_str_d};
                end
            end
            S_FIN: begin state_d = S_IDLE; tmr_d = '0; end
            default: begin state_d = S_IDLE; tmr_d = '0; end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            sel_q     <= '0;
            sync_q    <= '0;
            cnt_ref_q <= '0;
            cnt_str_q <= '0;
            delta_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            sel_q     <= sel_d;
            sync_q    <= {sync_q[1:0], tgl_sel};
            cnt_ref_q <= cnt_ref_d;
            cnt_str_q <= cnt_str_d;
            delta_q   <= delta_d;
            err_q     <= err_d;
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_FIN);
    assign err_o     = err_q;
    assign cnt_ref_o = cnt_ref_q;
    assign cnt_str_o = cnt_str_q;
    assign delta_o   = delta_q;
    assign ref_en_o  = ref_phase ? sel_oh : '0;
`ifdef ROSC_STRESS_EN
    assign str_en_o  = busy_o ? (str_phase ? sel_oh : '0) : '1;
`else
    assign str_en_o  = str_phase ? sel_oh : '0;
`endif

endmodule

// File: tb/tb_rosc_meas_ctrl.sv
// Directed bench for rosc_meas_ctrl: one instance with a short gate, one with narrow saturating counters.
module tb_rosc_meas_ctrl;

`ifdef ROSC_STRESS_EN
    localparam logic [3:0] IDLE_STR = 4'hF;
`else
    localparam logic [3:0] IDLE_STR = 4'h0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [2:0] sel_a = 3'd0, sel_b = 3'd0;
    logic [3:0] ref_tgl = 4'h0, str_tgl = 4'h0;

    logic [3:0]  ref_en_a, str_en_a, ref_en_b, str_en_b;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [15:0] cnt_ref_a, cnt_str_a;
    logic [16:0] delta_a;
    logic [3:0]  cnt_ref_b, cnt_str_b;
    logic [4:0]  delta_b;

    int n_pass = 0, n_tot = 0, n_fail = 0;
    int cyc = 0, lat = 0, pulses = 0;
    int ref_per = 0, str_per = 0;
    logic [3:0] ref_mask = 4'h0, str_mask = 4'h0;

    rosc_meas_ctrl #(.NUM_ROSC(4), .SEL_W(3), .CNT_W(16), .SETTLE_CYCLES(4), .GATE_CYCLES(16)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .sel_i(sel_a),
        .ref_tgl_i(ref_tgl), .str_tgl_i(str_tgl),
        .ref_en_o(ref_en_a), .str_en_o(str_en_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
        .cnt_ref_o(cnt_ref_a), .cnt_str_o(cnt_str_a), .delta_o(delta_a)
    );

    rosc_meas_ctrl #(.NUM_ROSC(4), .SEL_W(3), .CNT_W(4), .SETTLE_CYCLES(4), .GATE_CYCLES(32)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .sel_i(sel_b),
        .ref_tgl_i(ref_tgl), .str_tgl_i(str_tgl),
        .ref_en_o(ref_en_b), .str_en_o(str_en_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
        .cnt_ref_o(cnt_ref_b), .cnt_str_o(cnt_str_b), .delta_o(delta_b)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ref_per != 0 && (cyc % ref_per) == 0) ref_tgl = ref_tgl ^ ref_mask;
        if (str_per != 0 && (cyc % str_per) == 0) str_tgl = str_tgl ^ str_mask;
    endtask

    initial begin
        // Reset held two cycles
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy",    32'(busy_a),    32'd0);
        check("rst_done",    32'(done_a),    32'd0);
        check("rst_err",     32'(err_a),     32'd0);
        check("rst_ref_en",  32'(ref_en_a),  32'd0);
        check("rst_str_en",  32'(str_en_a),  32'(IDLE_STR));
        check("rst_cnt_ref", 32'(cnt_ref_a), 32'd0);
        check("rst_delta",   32'(delta_a),   32'd0);
        rst = 1'b0;
        tick();

        // Basic run: ref toggles every 2 cycles, str every 4, sel=2, overlapping START mid-run
        ref_mask = 4'b0100; ref_per = 2;
        str_mask = 4'b0100; str_per = 4;
        sel_a = 3'd2; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        lat = 1;
        check("basic_busy",   32'(busy_a),   32'd1);
        check("basic_ref_en", 32'(ref_en_a), 32'h4);
        check("basic_str_en_ref_phase", 32'(str_en_a), 32'h0);
        while (done_a !== 1'b1 && lat < 200) begin
            if (lat == 10) begin start_a = 1'b1; sel_a = 3'd1; end
            tick();
            lat++;
            start_a = 1'b0;
            if (lat == 11) begin
                check("overlap_no_err", 32'(err_a),    32'd0);
                check("overlap_ref_en", 32'(ref_en_a), 32'h4);
            end
            if (lat == 30) begin
                check("basic_str_en", 32'(str_en_a), 32'h4);
                check("basic_ref_en_off", 32'(ref_en_a), 32'h0);
            end
        end
        check("basic_latency", 32'(lat),       32'd41);
        check("basic_cnt_ref", 32'(cnt_ref_a), 32'd8);
        check("basic_cnt_str", 32'(cnt_str_a), 32'd4);
        check("basic_delta",   32'(delta_a),   32'd4);
        check("fin_str_en",    32'(str_en_a),  32'h0);
        check("fin_ref_en",    32'(ref_en_a),  32'h0);
        tick();
        check("post_done",    32'(done_a),    32'd0);
        check("post_busy",    32'(busy_a),    32'd0);
        check("hold_cnt_ref", 32'(cnt_ref_a), 32'd8);
        check("idle_str_en",  32'(str_en_a),  32'(IDLE_STR));
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done_a === 1'b1) pulses++;
        end
        check("overlap_single_done", 32'(pulses), 32'd0);

        // Settle exclusion: one toggle early in each settle window only
        ref_per = 0; str_per = 0;
        sel_a = 3'd2; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        lat = 1;
        while (done_a !== 1'b1 && lat < 200) begin
            if (lat == 1)  ref_tgl[2] = ~ref_tgl[2];
            if (lat == 21) str_tgl[2] = ~str_tgl[2];
            tick();
            lat++;
        end
        check("settle_latency", 32'(lat),       32'd41);
        check("settle_cnt_ref", 32'(cnt_ref_a), 32'd0);
        check("settle_cnt_str", 32'(cnt_str_a), 32'd0);
        check("settle_delta",   32'(delta_a),   32'd0);
        tick();

        // Illegal pair index
        sel_a = 3'd5; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("illegal_err",  32'(err_a),  32'd1);
        check("illegal_busy", 32'(busy_a), 32'd0);
        tick();
        check("illegal_err_pulse", 32'(err_a),  32'd0);
        check("illegal_busy2",     32'(busy_a), 32'd0);

        // Saturation on the 4-bit instance: ref toggles every cycle for a 32-cycle gate
        ref_mask = 4'b0001; ref_per = 1;
        sel_b = 3'd0; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        lat = 1;
        while (done_b !== 1'b1 && lat < 200) begin
            tick();
            lat++;
            if (lat == 10) begin
                check("sat_ref_en",         32'(ref_en_b), 32'h1);
                check("sat_str_en_ref_ph",  32'(str_en_b), 32'h0);
            end
            if (lat == 50) check("sat_str_en", 32'(str_en_b), 32'h1);
        end
        check("sat_latency", 32'(lat),       32'd73);
        check("sat_cnt_ref", 32'(cnt_ref_b), 32'd15);
        check("sat_cnt_str", 32'(cnt_str_b), 32'd0);
        check("sat_delta",   32'(delta_b),   32'd15);
        tick();

        // Reset in the middle of the reference count window
        ref_mask = 4'b0010; ref_per = 2;
        sel_a = 3'd1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid_busy_before", 32'(busy_a),   32'd1);
        check("mid_ref_en",      32'(ref_en_a), 32'h2);
        rst = 1'b1;
        tick();
        check("mid_rst_busy",    32'(busy_a),    32'd0);
        check("mid_rst_ref_en",  32'(ref_en_a),  32'h0);
        check("mid_rst_str_en",  32'(str_en_a),  32'(IDLE_STR));
        check("mid_rst_cnt_ref", 32'(cnt_ref_a), 32'd0);
        check("mid_rst_delta_b", 32'(delta_b),   32'd0);
        tick();
        check("mid_rst_done",    32'(done_a),    32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done_a === 1'b1 || busy_a === 1'b1) pulses++;
        end
        check("aborted_no_done", 32'(pulses), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
